controle_registrador: RTL and testbench
=======================================

CONTROLE_REGISTRADOR -- requirements
Module: controle_registrador

Interface
REQ-001 Parameter: LARGURA, 9, data width of the shared register (bits 8..0).
REQ-002 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 Port: pedido  input  4  write request, bit i from requester i; held high until ack[i] seen.
REQ-005 Port: dado0..dado3  input  LARGURA each  write data of requester 0..3.
REQ-006 Port: copie  output  1  load enable to the shared 9-bit register.
REQ-007 Port: entrada  output  LARGURA  data to the shared register's input.
REQ-008 Port: ack  output  4  one-hot write acknowledge to requester i.
REQ-009 Port: dono  output  2  index of requester whose data the register last loaded.
REQ-010 Port: valido  output  1  high once the register has been written since reset.
REQ-011 Port: ocupado  output  1  high whenever state is not OCIOSO.

Function
REQ-012 The block SHALL implement an FSM with states OCIOSO, CARREGA, ESPERA; all outputs Moore-decoded from registered state.
REQ-013 OCIOSO: if any pedido bit high, SHALL latch winner into vencedor (2 bits) and go to CARREGA; else stay.
REQ-014 Winner SHALL be chosen round-robin: first set pedido bit scanning ponteiro, ponteiro+1, ... modulo 4.
REQ-015 CARREGA SHALL last exactly one cycle: copie=1, entrada=dado[vencedor]; next state ESPERA.
REQ-016 Outside CARREGA, copie SHALL be 0 and entrada SHALL be all zeros.
REQ-017 On the CARREGA->ESPERA edge, dono SHALL take vencedor and valido SHALL become 1.
REQ-018 ESPERA: ack[vencedor]=1, other ack bits 0; stay while pedido[vencedor]=1.
REQ-019 ESPERA with pedido[vencedor]=0: SHALL set ponteiro=(vencedor+1) mod 4 and return to OCIOSO (wrap 3->0).
REQ-020 ack SHALL be 0 in OCIOSO and CARREGA; at most one ack bit high in any cycle.
REQ-021 Latency: pedido first high before edge k with FSM in OCIOSO -> copie high cycle k+1, ack high from cycle k+2.
REQ-022 pedido[vencedor] dropped during CARREGA: write SHALL still complete; ack high exactly one cycle in ESPERA.
REQ-023 Changes to non-winning pedido bits during CARREGA/ESPERA SHALL be ignored until next OCIOSO.
REQ-024 Minimum spacing between two copie pulses SHALL be 3 cycles (CARREGA, ESPERA, OCIOSO).
REQ-025 A requester re-raising pedido immediately after ack falls SHALL not win if another requester is pending (fairness via ponteiro).
REQ-026 Unused state encodings SHALL transition to OCIOSO on the next edge.

Reset
REQ-027 With reset=1 at a rising edge: state=OCIOSO, ponteiro=0, vencedor=0, dono=0, valido=0; copie=0, entrada=0, ack=0, ocupado=0 from next cycle.
REQ-028 reset SHALL take priority over every transition, including mid-CARREGA and mid-ESPERA; an interrupted CARREGA cycle is aborted and its write is not credited (dono/valido not updated).
REQ-029 After reset release, the first arbitration SHALL start from requester 0.

Verification
REQ-030 Single request: after reset, pedido=0001, dado0=9'h1A5 -> copie=1 with entrada=9'h1A5 one cycle; ack=0001 until pedido drops; dono=0, valido=1.
REQ-031 All request: pedido=1111 held, each dropped on its ack -> grants in order 0,1,2,3; copie pulses 3+ cycles apart; dono sequence 0,1,2,3.
REQ-032 Fairness/wrap: after granting 3, pedido=1001 -> requester 0 granted next (ponteiro wrapped to 0); then requester 3 re-raising -> granted after 0.
REQ-033 Early drop: pedido[2] pulsed one cycle from OCIOSO -> copie one cycle with dado2, ack=0100 exactly one cycle, back to OCIOSO.
REQ-034 Reset mid-operation: reset asserted in CARREGA -> next cycle copie=0, ack=0, ocupado=0, valido=0, dono=0; next grant from requester 0.
REQ-035 Idle: pedido=0000 for 20 cycles -> copie=0, ack=0, ocupado=0 throughout, dono/valido unchanged.

Source files
------------

// File: rtl/controle_registrador.sv
// Round-robin write arbiter for one shared register.
// Four requesters share it; grants rotate fairly among them.
module controle_registrador #(
    parameter int LARGURA = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         pedido,
    input  logic [LARGURA-1:0] dado0,
    input  logic [LARGURA-1:0] dado1,
    input  logic [LARGURA-1:0] dado2,
    input  logic [LARGURA-1:0] dado3,
    output logic               copie,
    output logic [LARGURA-1:0] entrada,
    output logic [3:0]         ack,
    output logic [1:0]         dono,
    output logic               valido,
    output logic               ocupado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CARREGA = 2'b01,
        ESPERA  = 2'b10
    } estado_t;

    estado_t    estado;
    estado_t    proximo;
    logic [1:0] ponteiro;
    logic [1:0] vencedor;
    logic [1:0] escolhido;
    logic [1:0] idx;
    logic       algum;

    // Scan from ponteiro downward in reverse so the nearest set bit wins last.
    always_comb begin
        escolhido = ponteiro;
        idx       = ponteiro;
        algum     = |pedido;
        for (int k = 3; k >= 0; k--) begin
            idx = ponteiro + 2'(k);
            if (pedido[idx]) begin
                escolhido = idx;
            end
        end
    end

    always_comb begin
        proximo = OCIOSO;
        unique case (estado)
            OCIOSO:  proximo = algum ? CARREGA : OCIOSO;
            CARREGA: proximo = ESPERA;
            ESPERA:  proximo = pedido[vencedor] ? ESPERA : OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            ponteiro <= 2'd0;
            vencedor <= 2'd0;
            dono     <= 2'd0;
            valido   <= 1'b0;
        end else begin
            estado <= proximo;
            if (estado == OCIOSO && algum) begin
                vencedor <= escolhido;
            end
            if (estado == CARREGA) begin
                dono   <= vencedor;
                valido <= 1'b1;
            end
            if (estado == ESPERA && !pedido[vencedor]) begin
                ponteiro <= vencedor + 2'd1;
            end
        end
    end

    always_comb begin
        copie   = (estado == CARREGA);
        ocupado = (estado != OCIOSO);
        entrada = '0;
        ack     = 4'b0000;
        if (estado == CARREGA) begin
            unique case (vencedor)
                2'd0:    entrada = dado0;
                2'd1:    entrada = dado1;
                2'd2:    entrada = dado2;
                default: entrada = dado3;
            endcase
        end
        if (estado == ESPERA) begin
            ack[vencedor] = 1'b1;
        end
    end

endmodule

// File: tb/tb_controle_registrador.sv
// Directed bench for the round-robin register arbiter.
// Expected values are hand-derived from the arbitration rules.
module tb_controle_registrador;

    localparam logic [8:0] D0 = 9'h1A5;
    localparam logic [8:0] D1 = 9'h0F3;
    localparam logic [8:0] D2 = 9'h15A;
    localparam logic [8:0] D3 = 9'h02C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pedido = 4'b0000;
    logic [8:0] dado0 = D0;
    logic [8:0] dado1 = D1;
    logic [8:0] dado2 = D2;
    logic [8:0] dado3 = D3;
    logic       copie;
    logic [8:0] entrada;
    logic [3:0] ack;
    logic [1:0] dono;
    logic       valido;
    logic       ocupado;

    int checks = 0;
    int erros  = 0;

    controle_registrador #(.LARGURA(9)) dut (
        .clock   (clock),
        .reset   (reset),
        .pedido  (pedido),
        .dado0   (dado0),
        .dado1   (dado1),
        .dado2   (dado2),
        .dado3   (dado3),
        .copie   (copie),
        .entrada (entrada),
        .ack     (ack),
        .dono    (dono),
        .valido  (valido),
        .ocupado (ocupado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            erros++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full grant: CARREGA, ESPERA, then drop to OCIOSO.
    task automatic grant(input int i, input logic [8:0] d,
                         input logic [3:0] depois);
        tick();
        check("copie_c", 32'(copie), 32'd1);
        check("entrada_c", 32'(entrada), 32'(d));
        check("ack_c", 32'(ack), 32'd0);
        check("ocupado_c", 32'(ocupado), 32'd1);
        tick();
        check("copie_e", 32'(copie), 32'd0);
        check("entrada_e", 32'(entrada), 32'd0);
        check("ack_e", 32'(ack), 32'(4'b0001 << i));
        check("dono_e", 32'(dono), 32'(i));
        check("valido_e", 32'(valido), 32'd1);
        pedido = depois;
        tick();
        check("ack_o", 32'(ack), 32'd0);
        check("ocupado_o", 32'(ocupado), 32'd0);
        check("copie_o", 32'(copie), 32'd0);
    endtask

    initial begin
        tick();
        reset = 1'b0;
        check("rst_copie", 32'(copie), 32'd0);
        check("rst_entrada", 32'(entrada), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_dono", 32'(dono), 32'd0);
        check("rst_valido", 32'(valido), 32'd0);

        // Single request, held for an extra ESPERA cycle
        pedido = 4'b0001;
        tick();
        check("s_copie", 32'(copie), 32'd1);
        check("s_entrada", 32'(entrada), 32'(D0));
        tick();
        check("s_ack1", 32'(ack), 32'b0001);
        check("s_valido", 32'(valido), 32'd1);
        tick();
        check("s_ack2", 32'(ack), 32'b0001);
        check("s_copie2", 32'(copie), 32'd0);
        pedido = 4'b0000;
        tick();
        check("s_ack_off", 32'(ack), 32'd0);
        check("s_ocupado", 32'(ocupado), 32'd0);

        // All requesters, fresh pointer
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        pedido = 4'b1111;
        grant(0, D0, 4'b1110);
        grant(1, D1, 4'b1100);
        grant(2, D2, 4'b1000);
        grant(3, D3, 4'b0000);

        // Wrap to 0, then 0 re-raises but 3 is pending
        pedido = 4'b1001;
        grant(0, D0, 4'b1000);
        pedido = 4'b1001;
        grant(3, D3, 4'b0001);
        grant(0, D0, 4'b0000);

        // Early drop during CARREGA
        pedido = 4'b0100;
        tick();
        pedido = 4'b0000;
        check("ed_copie", 32'(copie), 32'd1);
        check("ed_entrada", 32'(entrada), 32'(D2));
        tick();
        check("ed_ack", 32'(ack), 32'b0100);
        check("ed_dono", 32'(dono), 32'd2);
        tick();
        check("ed_ack_off", 32'(ack), 32'd0);
        check("ed_ocupado", 32'(ocupado), 32'd0);

        // Reset inside CARREGA; pointer was 3, must restart at 0
        pedido = 4'b0010;
        tick();
        check("rm_copie_c", 32'(copie), 32'd1);
        reset = 1'b1;
        tick();
        check("rm_copie", 32'(copie), 32'd0);
        check("rm_ack", 32'(ack), 32'd0);
        check("rm_ocupado", 32'(ocupado), 32'd0);
        check("rm_valido", 32'(valido), 32'd0);
        check("rm_dono", 32'(dono), 32'd0);
        reset  = 1'b0;
        pedido = 4'b1010;
        grant(1, D1, 4'b1000);
        grant(3, D3, 4'b0000);

        // Idle
        for (int n = 0; n < 20; n++) begin
            tick();
            check("id_copie", 32'(copie), 32'd0);
            check("id_ack", 32'(ack), 32'd0);
            check("id_ocupado", 32'(ocupado), 32'd0);
            check("id_dono", 32'(dono), 32'd3);
            check("id_valido", 32'(valido), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule
